// File: rtl/alu_pkg.sv
// Shared definitions for the execute-stage ALU: widths, function codes and
// operation groups.
package alu_pkg;

  localparam int DATA_W  = 32;
  localparam int SHAMT_W = 5;
  localparam int FUN_W   = 6;

  typedef enum logic [1:0] {
    GRP_ARITH = 2'b00,
    GRP_LOGIC = 2'b01,
    GRP_SHIFT = 2'b10,
    GRP_CMP   = 2'b11
  } alu_grp_e;

  localparam logic [FUN_W-1:0] ALU_ADD = 6'b00_0000;
  localparam logic [FUN_W-1:0] ALU_SUB = 6'b00_0001;
  localparam logic [FUN_W-1:0] ALU_AND = 6'b01_1000;
  localparam logic [FUN_W-1:0] ALU_OR  = 6'b01_1110;
  localparam logic [FUN_W-1:0] ALU_XOR = 6'b01_0110;
  localparam logic [FUN_W-1:0] ALU_NOR = 6'b01_0001;
  localparam logic [FUN_W-1:0] ALU_A   = 6'b01_1010;
  localparam logic [FUN_W-1:0] ALU_SLL = 6'b10_0000;
  localparam logic [FUN_W-1:0] ALU_SRL = 6'b10_0001;
  localparam logic [FUN_W-1:0] ALU_SRA = 6'b10_0011;
  localparam logic [FUN_W-1:0] ALU_EQ  = 6'b11_0011;
  localparam logic [FUN_W-1:0] ALU_NEQ = 6'b11_0001;
  localparam logic [FUN_W-1:0] ALU_LT  = 6'b11_0101;
  localparam logic [FUN_W-1:0] ALU_LEZ = 6'b11_1101;
  localparam logic [FUN_W-1:0] ALU_LTZ = 6'b11_1011;
  localparam logic [FUN_W-1:0] ALU_GTZ = 6'b11_1111;

endpackage

// File: rtl/alu_if.sv
// Operand/function bus between the execute-stage control and the ALU.
interface alu_if;
  import alu_pkg::*;

  logic [DATA_W-1:0] A;
  logic [DATA_W-1:0] B;
  logic [FUN_W-1:0]  ALUFun;
  logic              Sign;
  logic [DATA_W-1:0] Out;

  modport master (output A, output B, output ALUFun, output Sign, input Out);
  modport slave  (input A, input B, input ALUFun, input Sign, output Out);
endinterface

// File: rtl/alu_addsub.sv
// Combinational adder/subtractor with Z/N/V/C flags, shared by the
// arithmetic and compare groups.
module alu_addsub
  import alu_pkg::*;
(
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  input  logic              sub_i,
  output logic [DATA_W-1:0] res_o,
  output logic              z_o,
  output logic              n_o,
  output logic              v_o,
  output logic              c_o
);

  logic [DATA_W-1:0] b_eff;
  logic              carry;

  // Subtraction is A + ~B + 1; the carry-out is then the inverse of the borrow.
  assign b_eff = sub_i ? ~b_i : b_i;
  assign {carry, res_o} = {1'b0, a_i} + {1'b0, b_eff} + {{DATA_W{1'b0}}, sub_i};

  assign z_o = (res_o == '0);
  assign n_o = res_o[DATA_W-1];
  assign v_o = (a_i[DATA_W-1] == b_eff[DATA_W-1]) && (res_o[DATA_W-1] != a_i[DATA_W-1]);
  assign c_o = sub_i ? ~carry : carry;

endmodule

// File: rtl/alu.sv
// MIPS-style 32-bit ALU: arithmetic, logic, shift and compare with a
// single registered result stage.
module alu
  import alu_pkg::*;
(
  input  logic  clk,
  input  logic  reset,
  alu_if.slave  bus
);

  logic signed [DATA_W-1:0] a_s;
  logic signed [DATA_W-1:0] b_s;
  logic        [DATA_W-1:0] as_res;
  logic                     z, n, v, c;
  logic                     as_sub;
  alu_grp_e                 grp;
  logic        [DATA_W-1:0] out_d;
  logic        [DATA_W-1:0] out_q;

  function automatic logic [DATA_W-1:0] flag_word(input logic f);
    return {{(DATA_W-1){1'b0}}, f};
  endfunction

  assign a_s = bus.A;
  assign b_s = bus.B;
  assign grp = alu_grp_e'(bus.ALUFun[5:4]);

  // Compares always need A-B; only the arithmetic group may request an add.
  assign as_sub = (grp == GRP_CMP) || (bus.ALUFun == ALU_SUB);

  alu_addsub u_addsub (
    .a_i   (bus.A),
    .b_i   (bus.B),
    .sub_i (as_sub),
    .res_o (as_res),
    .z_o   (z),
    .n_o   (n),
    .v_o   (v),
    .c_o   (c)
  );

  always_comb begin
    out_d = '0;
    case (bus.ALUFun)
      ALU_ADD: out_d = as_res;
      ALU_SUB: out_d = as_res;
      ALU_AND: out_d = bus.A & bus.B;
      ALU_OR:  out_d = bus.A | bus.B;
      ALU_XOR: out_d = bus.A ^ bus.B;
      ALU_NOR: out_d = ~(bus.A | bus.B);
      ALU_A:   out_d = bus.A;
      ALU_SLL: out_d = bus.B << bus.A[SHAMT_W-1:0];
      ALU_SRL: out_d = bus.B >> bus.A[SHAMT_W-1:0];
      ALU_SRA: out_d = b_s >>> bus.A[SHAMT_W-1:0];
      ALU_EQ:  out_d = flag_word(z);
      ALU_NEQ: out_d = flag_word(~z);
      ALU_LT:  out_d = flag_word(bus.Sign ? (n ^ v) : c);
      // Zero-compares are signed on A alone, independent of Sign and B.
      ALU_LEZ: out_d = flag_word(a_s <= 0);
      ALU_LTZ: out_d = flag_word(a_s < 0);
      ALU_GTZ: out_d = flag_word(a_s > 0);
      default: out_d = '0;
    endcase
  end

  // Result register stage
  always_ff @(posedge clk) begin
    if (reset) out_q <= '0;
    else       out_q <= out_d;
  end

  assign bus.Out = out_q;

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: directed vector table plus a reference-model
// sweep, with a queue scoreboard aligned to the one-cycle result latency.
module tb_alu;
  import alu_pkg::*;

  logic clk;
  logic reset;
  alu_if bus();

  alu dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        rst;
    logic [5:0]  fun;
    logic        sign;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  typedef struct packed {
    logic [31:0] exp;
    logic [15:0] id;
  } sb_t;

  vec_t vecs[$];
  sb_t  exp_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic addv(input logic rst, input logic [5:0] fun, input logic sign,
                      input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp);
    vec_t v;
    v.rst = rst; v.fun = fun; v.sign = sign; v.a = a; v.b = b; v.exp = exp;
    vecs.push_back(v);
  endtask

  function automatic logic [31:0] model(input logic [5:0] fun, input logic sign,
                                        input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    r = 32'd0;
    case (fun)
      ALU_ADD: r = a + b;
      ALU_SUB: r = a - b;
      ALU_AND: r = a & b;
      ALU_OR:  r = a | b;
      ALU_XOR: r = a ^ b;
      ALU_NOR: r = ~(a | b);
      ALU_A:   r = a;
      ALU_SLL: r = b << a[4:0];
      ALU_SRL: r = b >> a[4:0];
      ALU_SRA: r = $unsigned($signed(b) >>> a[4:0]);
      ALU_EQ:  r = {31'd0, a == b};
      ALU_NEQ: r = {31'd0, a != b};
      ALU_LT:  r = {31'd0, sign ? ($signed(a) < $signed(b)) : (a < b)};
      ALU_LEZ: r = {31'd0, $signed(a) <= 0};
      ALU_LTZ: r = {31'd0, $signed(a) < 0};
      ALU_GTZ: r = {31'd0, $signed(a) > 0};
      default: r = 32'd0;
    endcase
    return r;
  endfunction

  // Drive on the falling edge; the rising edge captures the operation.
  task automatic drive(input vec_t v, input int id);
    sb_t s;
    @(negedge clk);
    reset      = v.rst;
    bus.A      = v.a;
    bus.B      = v.b;
    bus.ALUFun = v.fun;
    bus.Sign   = v.sign;
    s.exp = v.exp;
    s.id  = 16'(id);
    exp_q.push_back(s);
  endtask

  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      sb_t s;
      s = exp_q.pop_front();
      checks = checks + 1;
      if (bus.Out !== s.exp) begin
        errors = errors + 1;
        $display("FAIL vec%0d: Out=0x%08h expected 0x%08h", s.id, bus.Out, s.exp);
      end
    end
  end

  localparam logic [5:0] ILL0 = 6'b00_0111;
  localparam logic [5:0] ILL1 = 6'b01_1111;

  initial begin
    logic [5:0] codes [18];
    int         budget;
    vec_t       v;

    reset = 1'b1; bus.A = '0; bus.B = '0; bus.ALUFun = ALU_ADD; bus.Sign = 1'b1;

    // Reset and arithmetic/logic
    addv(1, ALU_ADD, 1, 32'd15, 32'd31, 32'h0000_0000);
    addv(1, ALU_ADD, 1, 32'd15, 32'd31, 32'h0000_0000);
    addv(0, ALU_ADD, 1, 32'd15, 32'd31, 32'h0000_002E);
    addv(0, ALU_SUB, 1, 32'd15, 32'd31, 32'hFFFF_FFF0);
    addv(0, ALU_AND, 1, 32'd15, 32'd31, 32'h0000_000F);
    addv(0, ALU_OR,  1, 32'd15, 32'd31, 32'h0000_001F);
    addv(0, ALU_XOR, 1, 32'd15, 32'd31, 32'h0000_0010);
    addv(0, ALU_NOR, 1, 32'd15, 32'd31, 32'hFFFF_FFE0);
    addv(0, ALU_A,   1, 32'd15, 32'd31, 32'h0000_000F);
    addv(0, ALU_ADD, 0, 32'hFFFF_FFFF, 32'd1, 32'h0000_0000);
    // Reset overrides a live operation
    addv(1, ALU_SUB, 1, 32'd15, 32'd31, 32'h0000_0000);
    // Shifts
    addv(0, ALU_SLL, 1, 32'd15, 32'd31, 32'h000F_8000);
    addv(0, ALU_SRL, 1, 32'd15, 32'd31, 32'h0000_0000);
    addv(0, ALU_SRA, 1, 32'd15, 32'd31, 32'h0000_0000);
    addv(0, ALU_SRA, 1, 32'd4, 32'h8000_0000, 32'hF800_0000);
    addv(0, ALU_SRL, 1, 32'd4, 32'h8000_0000, 32'h0800_0000);
    addv(0, ALU_SRL, 1, 32'hFFFF_FFE4, 32'h8000_0000, 32'h0800_0000);
    addv(0, ALU_SLL, 1, 32'd0, 32'h1234_5678, 32'h1234_5678);
    addv(0, ALU_SRA, 1, 32'd31, 32'h8000_0000, 32'hFFFF_FFFF);
    // Compares
    addv(0, ALU_EQ,  1, 32'd15, 32'd31, 32'd0);
    addv(0, ALU_NEQ, 1, 32'd15, 32'd31, 32'd1);
    addv(0, ALU_LT,  1, 32'd15, 32'd31, 32'd1);
    addv(0, ALU_LEZ, 1, 32'd15, 32'd31, 32'd0);
    addv(0, ALU_LTZ, 1, 32'd15, 32'd31, 32'd0);
    addv(0, ALU_GTZ, 1, 32'd15, 32'd31, 32'd1);
    addv(0, ALU_LEZ, 1, 32'd0, 32'd31, 32'd1);
    addv(0, ALU_GTZ, 1, 32'd0, 32'd31, 32'd0);
    addv(0, ALU_LTZ, 0, 32'hFFFF_FFFF, 32'd0, 32'd1);
    addv(0, ALU_EQ,  1, 32'd5, 32'd5, 32'd1);
    // Signedness and the overflow path
    addv(0, ALU_LT,  1, 32'hFFFF_FFFF, 32'd1, 32'd1);
    addv(0, ALU_LT,  0, 32'hFFFF_FFFF, 32'd1, 32'd0);
    addv(0, ALU_LT,  1, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'd0);
    addv(0, ALU_LT,  0, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'd1);
    // Illegal codes
    addv(0, ILL0,    1, 32'hDEAD_BEEF, 32'h1234_5678, 32'd0);
    addv(0, ILL1,    0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0);
    addv(0, ALU_NOR, 1, 32'd0, 32'd0, 32'hFFFF_FFFF);

    foreach (vecs[i]) drive(vecs[i], i);

    // Back-to-back random sweep checked against the reference model
    codes = '{ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_NOR, ALU_A, ALU_SLL,
              ALU_SRL, ALU_SRA, ALU_EQ, ALU_NEQ, ALU_LT, ALU_LEZ, ALU_LTZ, ALU_GTZ,
              ILL0, ILL1};
    for (int k = 0; k < 200; k++) begin
      v.rst  = 1'b0;
      v.fun  = codes[$urandom_range(0, 17)];
      v.sign = 1'($urandom_range(0, 1));
      v.a    = $urandom;
      v.b    = ($urandom_range(0, 7) == 0) ? v.a : $urandom;
      if ($urandom_range(0, 7) == 0) v.a = 32'h8000_0000;
      v.exp  = model(v.fun, v.sign, v.a, v.b);
      drive(v, 1000 + k);
    end

    budget = 20;
    while (exp_q.size() > 0 && budget > 0) begin
      @(negedge clk);
      budget = budget - 1;
    end
    if (exp_q.size() > 0) begin
      checks = checks + 1;
      errors = errors + 1;
      $display("FAIL drain: %0d results outstanding, expected 0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
